// File: rtl/ir_fetch_ctrl.sv
// Instruction fetch stage: owns the PC, issues one synchronous imem read per cycle and
// delivers words in PC order through a one-entry skid. Optional perf counters: IR_FETCH_PERF_EN.
module ir_fetch_ctrl #(
  parameter int               ADDR_W   = 16,
  parameter int               DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
`ifdef IR_FETCH_PERF_EN
  output logic [15:0]       o_fetch_cnt,
  output logic [15:0]       o_stall_cnt,
`endif
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_valid
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic              o_valid_q, o_valid_d;
  logic [DATA_W-1:0] o_data_q, o_data_d;
  logic [ADDR_W-1:0] o_pc_q, o_pc_d;

  assign imem_en   = rst & ~stall & ~redirect;
  assign imem_addr = pc_q;

  // Priority: redirect > stall > run. The skid only fills on the first stalled edge,
  // because inflight is cleared there and no new fetch issues until the stall ends.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_data_d   = skid_data_q;
    skid_pc_d     = skid_pc_q;
    o_valid_d     = o_valid_q;
    o_data_d      = o_data_q;
    o_pc_d        = o_pc_q;
    if (redirect) begin
      pc_d         = redirect_pc;
      inflight_d   = 1'b0;
      skid_valid_d = 1'b0;
      o_valid_d    = 1'b0;
    end else if (stall) begin
      if (inflight_q) begin
        skid_valid_d = 1'b1;
        skid_data_d  = imem_rdata;
        skid_pc_d    = inflight_pc_q;
      end
      inflight_d = 1'b0;
    end else begin
      pc_d          = pc_q + ADDR_W'(1);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      if (skid_valid_q) begin
        o_valid_d    = 1'b1;
        o_data_d     = skid_data_q;
        o_pc_d       = skid_pc_q;
        skid_valid_d = 1'b0;
      end else if (inflight_q) begin
        o_valid_d = 1'b1;
        o_data_d  = imem_rdata;
        o_pc_d    = inflight_pc_q;
      end else begin
        o_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      inflight_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      o_valid_q    <= 1'b0;
      o_data_q     <= '0;
      o_pc_q       <= '0;
    end else begin
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      skid_valid_q <= skid_valid_d;
      o_valid_q    <= o_valid_d;
      o_data_q     <= o_data_d;
      o_pc_q       <= o_pc_d;
    end
  end

  // Payload registers are qualified by inflight/skid_valid, so they need no reset.
  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
    skid_data_q   <= skid_data_d;
    skid_pc_q     <= skid_pc_d;
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_pc    = o_pc_q;

`ifdef IR_FETCH_PERF_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    fetch_cnt_d = imem_en ? sat_inc(fetch_cnt_q) : fetch_cnt_q;
    stall_cnt_d = stall   ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_fetch_cnt = fetch_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// Self-checking bench for ir_fetch_ctrl: directed scenarios plus random stall/redirect
// traffic against a queue-based stream model. Honours IR_FETCH_PERF_EN if defined.
module tb_ir_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] o_data;
  logic [15:0] o_pc;
  logic        o_valid;

  logic        w_imem_en;
  logic [15:0] w_imem_addr;
  logic [15:0] w_imem_rdata;
  logic [15:0] w_o_data;
  logic [15:0] w_o_pc;
  logic        w_o_valid;
`ifdef IR_FETCH_PERF_EN
  logic [15:0] o_fetch_cnt, o_stall_cnt, w_fetch_cnt, w_stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ir_fetch_ctrl #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
`ifdef IR_FETCH_PERF_EN
    .o_fetch_cnt(o_fetch_cnt), .o_stall_cnt(o_stall_cnt),
`endif
    .o_data(o_data), .o_pc(o_pc), .o_valid(o_valid)
  );

  ir_fetch_ctrl #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(16'h0000),
    .imem_en(w_imem_en), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
`ifdef IR_FETCH_PERF_EN
    .o_fetch_cnt(w_fetch_cnt), .o_stall_cnt(w_stall_cnt),
`endif
    .o_data(w_o_data), .o_pc(w_o_pc), .o_valid(w_o_valid)
  );

  // Synchronous instruction memories: rdata = addr ^ 16'hA500, one cycle after the read.
  always @(posedge clk) begin
    if (imem_en)   imem_rdata   <= imem_addr ^ 16'hA500;
    if (w_imem_en) w_imem_rdata <= w_imem_addr ^ 16'hA500;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: fetches issued but not yet delivered live in a queue, delivered in order.
  logic [15:0] m_pc, m_opc, m_odata, m_fc, m_sc;
  logic        m_ov;
  logic [15:0] m_q[$];

  task automatic model_reset();
    m_pc = 16'h0000; m_ov = 1'b0; m_opc = 16'h0000; m_odata = 16'h0000;
    m_fc = 16'h0000; m_sc = 16'h0000;
    m_q.delete();
  endtask

  task automatic model_edge();
    if (!rst) begin
      model_reset();
    end else begin
      if (!stall && !redirect && m_fc != 16'hFFFF) m_fc++;
      if (stall && m_sc != 16'hFFFF) m_sc++;
      if (redirect) begin
        m_q.delete();
        m_ov = 1'b0;
        m_pc = redirect_pc;
      end else if (!stall) begin
        if (m_q.size() > 0) begin
          m_opc   = m_q.pop_front();
          m_odata = m_opc ^ 16'hA500;
          m_ov    = 1'b1;
        end else begin
          m_ov = 1'b0;
        end
        m_q.push_back(m_pc);
        m_pc = m_pc + 16'd1;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("o_valid", o_valid, m_ov);
    check_eq("o_pc", o_pc, m_opc);
    check_eq("o_data", o_data, m_odata);
`ifdef IR_FETCH_PERF_EN
    check_eq("fetch_cnt", o_fetch_cnt, m_fc);
    check_eq("stall_cnt", o_stall_cnt, m_sc);
`endif
  endtask

  // Called just after a falling edge: drive inputs, check combinational outputs, advance one cycle.
  task automatic cycle(input logic s, input logic r, input logic [15:0] rp);
    stall = s; redirect = r; redirect_pc = rp;
    #1;
    check_eq("imem_en", imem_en, rst & ~s & ~r);
    check_eq("imem_addr", imem_addr, m_pc);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic [15:0] wexp;
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_eq("rst_imem_en", imem_en, 1'b0);
    check_outputs();

    // Reset release: stream from 0; wrap instance shows FFFE, FFFF, 0000, ...
    rst = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      cycle(1'b0, 1'b0, 16'h0000);
      if (n == 2) check_eq("first_valid_pc", o_pc, 16'h0000);
      check_eq("wrap_valid", w_o_valid, (n >= 2));
      if (n >= 2) begin
        wexp = 16'hFFFE + 16'(n - 2);
        check_eq("wrap_pc", w_o_pc, wexp);
        check_eq("wrap_data", w_o_data, wexp ^ 16'hA500);
      end
    end

    // Four-cycle stall at o_pc = 5, then 6, 7, 8 with no gap.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 16'h0000);
      check_eq("stall_hold_pc", o_pc, 16'h0005);
      check_eq("stall_hold_data", o_data, 16'hA505);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 16'h0000);
      check_eq("resume_pc", o_pc, 16'(6 + i));
      check_eq("resume_valid", o_valid, 1'b1);
    end

    // Redirect to 0x0100.
    cycle(1'b0, 1'b1, 16'h0100);
    cycle(1'b0, 1'b0, 16'h0000);
    check_eq("redir_bubble", o_valid, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000);
    check_eq("redir_target", o_pc, 16'h0100);
    cycle(1'b0, 1'b0, 16'h0000);
    check_eq("redir_next", o_pc, 16'h0101);

    // Redirect together with stall (skid full from the preceding stall edge).
    cycle(1'b1, 1'b0, 16'h0000);
    cycle(1'b1, 1'b1, 16'h0200);
    cycle(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0000);
    check_eq("redir_stall_pc", o_pc, 16'h0201);

    // Asynchronous reset in the middle of a stall with the skid full.
    cycle(1'b1, 1'b0, 16'h0000);
    cycle(1'b1, 1'b0, 16'h0000);
    #2; rst = 1'b0; #1;
    model_reset();
    check_eq("async_rst_valid", o_valid, 1'b0);
    check_eq("async_rst_pc", o_pc, 16'h0000);
    check_eq("async_rst_data", o_data, 16'h0000);
    check_eq("async_rst_en", imem_en, 1'b0);
    @(posedge clk); model_edge();
    @(negedge clk); check_outputs();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 16'h0000);
    check_eq("restart_pc", o_pc, 16'h0003);

    // Random stall/redirect traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
